// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared definitions for the 4x4 matrix-keypad emulator and the
//             keypad decoder: state encoding, key-to-matrix map and the
//             LFSR constants used to generate contact bounce.
//  Contents : kp_emu_state_t, ST_* state constants, key_to_row/key_to_col,
//             LFSR_SEED, LFSR_TAP_MASK
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    KP_IDLE           = 2'd0,
    KP_BOUNCE_PRESS   = 2'd1,
    KP_HELD           = 2'd2,
    KP_BOUNCE_RELEASE = 2'd3
  } kp_emu_state_t;

  // Plain-vector copies of the encoding for the state register.
  localparam logic [1:0] ST_IDLE           = KP_IDLE;
  localparam logic [1:0] ST_BOUNCE_PRESS   = KP_BOUNCE_PRESS;
  localparam logic [1:0] ST_HELD           = KP_HELD;
  localparam logic [1:0] ST_BOUNCE_RELEASE = KP_BOUNCE_RELEASE;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 counted from the output end of a
  // right-shifting register, so feedback = bit0 ^ bit2 ^ bit3 ^ bit5.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  // Physical layout:
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
  function automatic logic [1:0] key_to_row(input logic [3:0] key);
    logic [1:0] row;
    case (key)
      4'h1, 4'h2, 4'h3, 4'hA: row = 2'd0;
      4'h4, 4'h5, 4'h6, 4'hB: row = 2'd1;
      4'h7, 4'h8, 4'h9, 4'hC: row = 2'd2;
      default:                row = 2'd3; // 0, F, E, D
    endcase
    return row;
  endfunction

  function automatic logic [1:0] key_to_col(input logic [3:0] key);
    logic [1:0] col;
    case (key)
      4'h1, 4'h4, 4'h7, 4'h0: col = 2'd0;
      4'h2, 4'h5, 4'h8, 4'hF: col = 2'd1;
      4'h3, 4'h6, 4'h9, 4'hE: col = 2'd2;
      default:                col = 2'd3; // A, B, C, D
    endcase
    return col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator_if
//  Purpose  : Bundles the press-request handshake and the keypad matrix lines
//             between a requester/scanner and the keypad emulator.
//  Signals  : col_in[3:0]   column drive from scanner, active-low
//             row_out[3:0]  row lines to scanner, active-low, idle high
//             key_code[3:0], hold_ms[7:0], press_valid  request
//             press_ready, busy, done                   status
//  Modports : master (requester / scanner side), slave (emulator side)
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_emulator_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic [7:0] hold_ms;
  logic       press_valid;
  logic       press_ready;
  logic       busy;
  logic       done;

  modport master (
    output col_in, key_code, hold_ms, press_valid,
    input  row_out, press_ready, busy, done
  );

  modport slave (
    input  col_in, key_code, hold_ms, press_valid,
    output row_out, press_ready, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/keypad_emulator_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : 16-bit Fibonacci LFSR used as the contact-bounce noise source.
//             Reseed has priority over enable; resets to LFSR_SEED.
//  Ports    : clk, rst (async, active-high), en (advance one step),
//             reseed (load LFSR_SEED), lfsr_out[15:0] (current state)
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        reseed,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = LFSR_SEED;
    end else if (en) begin
      lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator
//  Purpose  : Plays one scripted key press (press bounce, clean hold, release
//             bounce) on the row lines of a 4x4 matrix keypad in response to
//             the scanner's active-low column drive.
//  Params   : clk_freq    clock frequency in Hz (1 ms = clk_freq/1000 cycles)
//             bounce_time length of each bounce phase in ms
//  Ports    : clk, rst (async, active-high)
//             bus (keypad_emulator_if.slave): col_in, row_out, key_code,
//             hold_ms, press_valid, press_ready, busy, done
//  Config   : KEYPAD_EMU_BOUNCE_EN - when defined, the bounce phases and the
//             LFSR are built; otherwise IDLE -> HELD -> IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int clk_freq    = 125_000_000,
  parameter int bounce_time = 2
) (
  input  logic              clk,
  input  logic              rst,
  keypad_emulator_if.slave  bus
);

  localparam int                  MS_CYC     = clk_freq / 1000;
  localparam int                  PRESC_W    = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(MS_CYC - 1);
  localparam logic [7:0]          BOUNCE_MS  = 8'(bounce_time);

  logic [1:0]         state_q,   state_d;
  logic [1:0]         key_row_q, key_row_d;
  logic [1:0]         key_col_q, key_col_d;
  logic [7:0]         hold_q,    hold_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic [7:0]         ms_q,      ms_d;
  logic [3:0]         row_out_q, row_out_d;

  logic       accept;
  logic       ms_wrap;
  logic       phase_end;
  logic [7:0] phase_ms;
  logic       contact;
  logic       lfsr_bit;
  logic       in_bounce;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [15:0] lfsr_state;
  logic        lfsr_unused;

  lfsr16 u_lfsr16 (
    .clk      (clk),
    .rst      (rst),
    .en       (in_bounce),
    .reseed   (accept),
    .lfsr_out (lfsr_state)
  );

  assign lfsr_bit    = lfsr_state[0];
  assign lfsr_unused = ^lfsr_state[15:1];
`else
  // Bounce states are unreachable in this build.
  assign lfsr_bit = 1'b0;
`endif

  always_comb begin
    accept    = bus.press_valid && (state_q == ST_IDLE);
    in_bounce = (state_q == ST_BOUNCE_PRESS) || (state_q == ST_BOUNCE_RELEASE);

    case (state_q)
      ST_BOUNCE_PRESS,
      ST_BOUNCE_RELEASE: phase_ms = BOUNCE_MS;
      ST_HELD:           phase_ms = hold_q;
      default:           phase_ms = 8'd1;
    endcase

    // A phase ends on the prescaler wrap that completes its last ms.
    ms_wrap   = (presc_q == PRESC_LAST);
    phase_end = ms_wrap && (ms_q == phase_ms - 8'd1);

    state_d   = state_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          key_row_d = key_to_row(bus.key_code);
          key_col_d = key_to_col(bus.key_code);
          hold_d    = (bus.hold_ms == 8'd0) ? 8'd1 : bus.hold_ms;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d   = ST_BOUNCE_PRESS;
`else
          state_d   = ST_HELD;
`endif
        end
      end
      ST_BOUNCE_PRESS: begin
        if (phase_end) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (phase_end) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = ST_BOUNCE_RELEASE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_BOUNCE_RELEASE: begin
        if (phase_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change (acceptance included) and is
    // parked at zero while idle.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      presc_d = '0;
      ms_d    = 8'd0;
    end else if (ms_wrap) begin
      presc_d = '0;
      ms_d    = ms_q + 8'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
      ms_d    = ms_q;
    end

    case (state_q)
      ST_BOUNCE_PRESS,
      ST_BOUNCE_RELEASE: contact = lfsr_bit;
      ST_HELD:           contact = 1'b1;
      default:           contact = 1'b0;
    endcase

    // Closed contact shorts the latched row to the latched column, so the
    // row follows that column's drive; other columns are ignored.
    row_out_d            = 4'hF;
    row_out_d[key_row_q] = ~(contact & ~bus.col_in[key_col_q]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      hold_q    <= 8'd0;
      presc_q   <= '0;
      ms_q      <= 8'd0;
      row_out_q <= 4'hF;
    end else begin
      state_q   <= state_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      hold_q    <= hold_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      row_out_q <= row_out_d;
    end
  end

  assign bus.row_out     = row_out_q;
  assign bus.press_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  // Pulses in the last cycle of the final phase, independent of col_in.
  assign bus.done        = (state_q != ST_IDLE) && (state_d == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emulator
//  Purpose  : Directed self-checking bench for keypad_emulator at 8 cycles/ms
//             and bounce_time = 2. Works with or without KEYPAD_EMU_BOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  localparam int CLK_FREQ = 8000;
  localparam int MS       = 8;
  localparam int BT       = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B_CYC = BT * MS;
`else
  localparam int B_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_emulator_if bus ();

  keypad_emulator #(
    .clk_freq    (CLK_FREQ),
    .bounce_time (BT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Key map written out from the keypad layout (index = key code).
  int key_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int key_col [16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};
  logic [3:0] col_pat [6] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011, 4'b0000, 4'b1111};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full press. The acceptance edge happens inside this task; cycle n=1
  // is the cycle right after it. With keep=1, press_valid stays high and the
  // request fields switch to nkey/nhold while busy.
  task automatic run_press(input logic [3:0] key, input logic [7:0] hold, input bit keep,
                           input logic [3:0] nkey, input logic [7:0] nhold, input string tag);
    int         hc;
    int         total;
    bit         bounce;
    logic [15:0] lf;
    logic [3:0]  exp_row;
    logic [3:0]  col;
    logic        contact;
    hc      = ((hold == 8'd0) ? 1 : int'(hold)) * MS;
    total   = 2 * B_CYC + hc;
    lf      = 16'hACE1;
    exp_row = 4'hF;
    bus.key_code    = key;
    bus.hold_ms     = hold;
    bus.press_valid = 1'b1;
    @(posedge clk); #1;
    if (keep) begin
      bus.key_code = nkey;
      bus.hold_ms  = nhold;
    end else begin
      bus.press_valid = 1'b0;
    end
    for (int n = 1; n <= total + 1; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      chk({tag, "_row"},   32'(bus.row_out),     32'(exp_row));
      chk({tag, "_busy"},  32'(bus.busy),        32'(n <= total));
      chk({tag, "_done"},  32'(bus.done),        32'(n == total));
      chk({tag, "_ready"}, 32'(bus.press_ready), 32'(n > total));
      bounce  = (n <= B_CYC) || ((n > B_CYC + hc) && (n <= total));
      contact = (n > total) ? 1'b0 : (bounce ? lf[0] : 1'b1);
      col     = col_pat[n % 6];
      bus.col_in = col;
      exp_row = 4'hF;
      exp_row[key_row[key]] = ~(contact & ~col[key_col[key]]);
      if (bounce) lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.col_in      = 4'hF;
    bus.key_code    = 4'h0;
    bus.hold_ms     = 8'd0;
    bus.press_valid = 1'b0;

    // Reset defaults, column activity ignored while in reset.
    @(posedge clk); #1;
    chk("rst_row",   32'(bus.row_out),     32'hF);
    chk("rst_ready", 32'(bus.press_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_done",  32'(bus.done),        32'd0);
    bus.col_in = 4'b0000;
    @(posedge clk); #1;
    chk("rst_col0_row", 32'(bus.row_out), 32'hF);
    bus.col_in = 4'b1010;
    @(posedge clk); #1;
    chk("rst_colA_row", 32'(bus.row_out), 32'hF);
    rst = 1'b0;
    bus.col_in = 4'b0000;
    @(posedge clk); #1;
    chk("idle_row",   32'(bus.row_out),     32'hF);
    chk("idle_ready", 32'(bus.press_ready), 32'd1);

    // Clean-hold mapping on key 5 (row1,col1).
    run_press(4'h5, 8'd3, 1'b0, 4'h0, 8'd0, "k5");
    // Full sequence on key D (row3,col3).
    run_press(4'hD, 8'd3, 1'b0, 4'h0, 8'd0, "kD");
    // Request held while busy, fields change to key 2 / hold 0 mid-press.
    run_press(4'h9, 8'd1, 1'b1, 4'h2, 8'd0, "k9busy");
    run_press(4'h2, 8'd0, 1'b0, 4'h0, 8'd0, "k2h0");

    // Asynchronous reset in the middle of HELD.
    bus.key_code    = 4'hD;
    bus.hold_ms     = 8'd3;
    bus.press_valid = 1'b1;
    @(posedge clk); #1;
    bus.press_valid = 1'b0;
    bus.col_in      = 4'b0000;
    repeat (B_CYC + 5) @(posedge clk);
    #1;
    chk("mid_held_row",  32'(bus.row_out), 32'b0111);
    chk("mid_held_busy", 32'(bus.busy),    32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_row",   32'(bus.row_out),     32'hF);
    chk("mid_rst_busy",  32'(bus.busy),        32'd0);
    chk("mid_rst_ready", 32'(bus.press_ready), 32'd1);
    chk("mid_rst_done",  32'(bus.done),        32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_press(4'hD, 8'd3, 1'b0, 4'h0, 8'd0, "kD_again");

    // Short hold (16 cycles when bounce is compiled out).
    run_press(4'h7, 8'd2, 1'b0, 4'h0, 8'd0, "k7h2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
